// File: rtl/packet_sink.sv
// Packet sink: grants a sender, then receives a head / BODY_COUNT bodies / tail packet
// and keeps statistics. Define PACKET_SINK_SEQ_CHECK_EN to enable payload sequence checking.
package router_pkg;
    typedef enum logic [1:0] {
        NONE_FLIT = 2'd0,
        HEAD_FLIT = 2'd1,
        BODY_FLIT = 2'd2,
        TAIL_FLIT = 2'd3
    } flit_type_e;

    typedef struct packed {
        logic       valid;
        flit_type_e ftype;
    } flit_head_t;

    // Head carries an address, body carries data, tail carries a reserved word.
    typedef union packed {
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] reserved;
    } flit_payload_t;

    typedef struct packed {
        flit_head_t    head;
        flit_payload_t payload;
    } FLIT_t;
endpackage

module packet_sink
    import router_pkg::*;
#(
    parameter int BODY_COUNT = 2,
    parameter int TIMEOUT    = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_req,
    output logic        o_grant,
    input  logic        i_flit_valid,
    input  FLIT_t       i_flit,
    output logic        o_busy,
    output logic        o_pkt_done,
    output logic        o_pkt_err,
    output logic [1:0]  o_err_code,
    output logic [15:0] o_pkt_count,
    output logic [7:0]  o_err_count,
    output logic [15:0] o_last_addr,
    output logic [15:0] o_checksum
);
    localparam int IDLE_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT     = 2'd1,
        WAIT_HEAD = 2'd2,
        RECV_BODY = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [7:0]        body_cnt_q, body_cnt_d;
    logic [15:0]       addr_q, addr_d;
    logic [15:0]       csum_q, csum_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [15:0]       pkt_count_q, pkt_count_d;
    logic [7:0]        err_count_q, err_count_d;
    logic [15:0]       last_addr_q, last_addr_d;
    logic [15:0]       checksum_q, checksum_d;
`ifdef PACKET_SINK_SEQ_CHECK_EN
    logic [15:0]       prev_q, prev_d;
`endif

    logic        accept;
    logic        in_pkt;
    logic        body_full;
    logic        frame_err;
    logic        seq_err;
    logic        tmo_err;
    logic        pkt_ok;
    logic        pkt_good;
    logic        any_err;
    logic [1:0]  err_sel;
    flit_type_e  kind;
    logic [15:0] payload;

    assign accept    = i_flit_valid && i_flit.head.valid;
    assign kind      = i_flit.head.ftype;
    assign payload   = i_flit.payload.data;
    assign in_pkt    = (state_q == WAIT_HEAD) || (state_q == RECV_BODY);
    assign body_full = (body_cnt_q == 8'(BODY_COUNT));

    // Classify the current cycle: framing, sequence, timeout or packet completion.
    always_comb begin
        frame_err = 1'b0;
        seq_err   = 1'b0;
        tmo_err   = 1'b0;
        pkt_ok    = 1'b0;
        if (accept) begin
            case (state_q)
                WAIT_HEAD: frame_err = (kind != HEAD_FLIT);
                RECV_BODY: begin
                    case (kind)
                        BODY_FLIT: frame_err = body_full;
                        TAIL_FLIT: begin
                            frame_err = !body_full;
                            pkt_ok    = body_full;
                        end
                        default:   frame_err = 1'b1;
                    endcase
                end
                default: ;
            endcase
        end else if (in_pkt) begin
            tmo_err = (idle_cnt_q == IDLE_W'(TIMEOUT - 1));
        end
`ifdef PACKET_SINK_SEQ_CHECK_EN
        if (accept && (state_q == RECV_BODY) &&
            ((kind == BODY_FLIT) || (kind == TAIL_FLIT)) &&
            (payload != prev_q + 16'd1)) begin
            seq_err = 1'b1;
        end
`endif
    end

    assign any_err  = frame_err || seq_err || tmo_err;
    assign pkt_good = pkt_ok && !seq_err;

    always_comb begin
        if (frame_err) begin
            err_sel = 2'd1;
        end else if (seq_err) begin
            err_sel = 2'd3;
        end else begin
            err_sel = 2'd2;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_req) begin
                    state_d = GRANT;
                end
            end
            GRANT:     state_d = WAIT_HEAD;
            WAIT_HEAD: begin
                if (any_err) begin
                    state_d = IDLE;
                end else if (accept) begin
                    state_d = RECV_BODY;
                end
            end
            RECV_BODY: begin
                if (any_err || pkt_good) begin
                    state_d = IDLE;
                end
            end
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        o_grant = (state_q == GRANT);
        o_busy  = (state_q != IDLE);
    end

    always_comb begin
        idle_cnt_d  = '0;
        body_cnt_d  = body_cnt_q;
        addr_d      = addr_q;
        csum_d      = csum_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        err_code_d  = err_code_q;
        pkt_count_d = pkt_count_q;
        err_count_d = err_count_q;
        last_addr_d = last_addr_q;
        checksum_d  = checksum_q;
`ifdef PACKET_SINK_SEQ_CHECK_EN
        prev_d      = prev_q;
        if (accept && in_pkt) begin
            prev_d = payload;
        end
`endif

        // The idle run restarts on every accepted flit and on entering WAIT_HEAD.
        if (in_pkt && !accept) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end

        if (accept && (state_q == WAIT_HEAD) && !frame_err) begin
            addr_d     = payload;
            csum_d     = payload;
            body_cnt_d = '0;
        end

        if (accept && (state_q == RECV_BODY) && (kind == BODY_FLIT) && !any_err) begin
            body_cnt_d = body_cnt_q + 8'd1;
            csum_d     = csum_q ^ payload;
        end

        if (pkt_good) begin
            done_d      = 1'b1;
            err_code_d  = 2'd0;
            last_addr_d = addr_q;
            checksum_d  = csum_q ^ payload;
            if (pkt_count_q != 16'hFFFF) begin
                pkt_count_d = pkt_count_q + 16'd1;
            end
        end

        if (any_err) begin
            err_d      = 1'b1;
            err_code_d = err_sel;
            if (err_count_q != 8'hFF) begin
                err_count_d = err_count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idle_cnt_q  <= '0;
            body_cnt_q  <= '0;
            addr_q      <= '0;
            csum_q      <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= '0;
            pkt_count_q <= '0;
            err_count_q <= '0;
            last_addr_q <= '0;
            checksum_q  <= '0;
`ifdef PACKET_SINK_SEQ_CHECK_EN
            prev_q      <= '0;
`endif
        end else begin
            idle_cnt_q  <= idle_cnt_d;
            body_cnt_q  <= body_cnt_d;
            addr_q      <= addr_d;
            csum_q      <= csum_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            pkt_count_q <= pkt_count_d;
            err_count_q <= err_count_d;
            last_addr_q <= last_addr_d;
            checksum_q  <= checksum_d;
`ifdef PACKET_SINK_SEQ_CHECK_EN
            prev_q      <= prev_d;
`endif
        end
    end

    assign o_pkt_done  = done_q;
    assign o_pkt_err   = err_q;
    assign o_err_code  = err_code_q;
    assign o_pkt_count = pkt_count_q;
    assign o_err_count = err_count_q;
    assign o_last_addr = last_addr_q;
    assign o_checksum  = checksum_q;

endmodule

// File: tb/tb_packet_sink.sv
// Directed testbench for packet_sink (BODY_COUNT=2, TIMEOUT=8); honours PACKET_SINK_SEQ_CHECK_EN.
module tb_packet_sink;
    import router_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_req;
    logic        o_grant;
    logic        i_flit_valid;
    FLIT_t       i_flit;
    logic        o_busy;
    logic        o_pkt_done;
    logic        o_pkt_err;
    logic [1:0]  o_err_code;
    logic [15:0] o_pkt_count;
    logic [7:0]  o_err_count;
    logic [15:0] o_last_addr;
    logic [15:0] o_checksum;

    int total = 0;
    int bad   = 0;
    int exp_pkt = 0;
    int exp_err = 0;

    always #5 clk = ~clk;

    packet_sink #(.BODY_COUNT(2), .TIMEOUT(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_req        (i_req),
        .o_grant      (o_grant),
        .i_flit_valid (i_flit_valid),
        .i_flit       (i_flit),
        .o_busy       (o_busy),
        .o_pkt_done   (o_pkt_done),
        .o_pkt_err    (o_pkt_err),
        .o_err_code   (o_err_code),
        .o_pkt_count  (o_pkt_count),
        .o_err_count  (o_err_count),
        .o_last_addr  (o_last_addr),
        .o_checksum   (o_checksum)
    );

    function automatic FLIT_t mk(flit_type_e k, logic [15:0] p, logic hv);
        FLIT_t f;
        f.head.valid   = hv;
        f.head.ftype   = k;
        f.payload.data = p;
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(flit_type_e k, logic [15:0] p);
        i_flit_valid = 1'b1;
        i_flit       = mk(k, p, 1'b1);
        tick();
        i_flit_valid = 1'b0;
        i_flit       = mk(NONE_FLIT, 16'h0, 1'b0);
    endtask

    task automatic request();
        i_req = 1'b1;
        tick();
        i_req = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        i_req = 1'b0;
        i_flit_valid = 1'b0;
        i_flit = mk(NONE_FLIT, 16'h0, 1'b0);
        tick();
        tick();
        total++;
        if ({o_busy, o_grant, o_pkt_done, o_pkt_err, o_err_code, o_pkt_count, o_err_count,
             o_last_addr, o_checksum} !== 72'h0) begin
            bad++;
            $display("FAIL reset_outputs: got busy=%b cnt=%h err=%h addr=%h csum=%h want all 0",
                     o_busy, o_pkt_count, o_err_count, o_last_addr, o_checksum);
        end
        reset_n = 1'b1;
        tick();
        total++;
        if ({o_grant, o_pkt_done, o_pkt_err} !== 3'b000) begin
            bad++;
            $display("FAIL reset_release_pulses: got %b want 000", {o_grant, o_pkt_done, o_pkt_err});
        end
        $display("reset: outputs cleared, released");
    endtask

    task automatic test_idle_ignore();
        drive(HEAD_FLIT, 16'h0099);
        drive(BODY_FLIT, 16'h009A);
        total++;
        if ({o_busy, o_pkt_err, o_err_count} !== 10'h0) begin
            bad++;
            $display("FAIL idle_ignore: got busy=%b err=%b errcnt=%h want 0", o_busy, o_pkt_err, o_err_count);
        end
        $display("idle: flits ignored busy=%b", o_busy);
    endtask

    task automatic test_good();
        i_req = 1'b1;
        tick();
        total++;
        if ({o_grant, o_busy} !== 2'b11) begin
            bad++;
            $display("FAIL good_grant: got grant/busy=%b want 11", {o_grant, o_busy});
        end
        i_req = 1'b0;
        tick();
        total++;
        if (o_grant !== 1'b0) begin
            bad++;
            $display("FAIL good_grant_one_cycle: got %b want 0", o_grant);
        end
        drive(HEAD_FLIT, 16'h0010);
        drive(BODY_FLIT, 16'h0011);
        drive(BODY_FLIT, 16'h0012);
        total++;
        if ({o_busy, o_pkt_done} !== 2'b10) begin
            bad++;
            $display("FAIL good_midpkt: got busy/done=%b want 10", {o_busy, o_pkt_done});
        end
        drive(TAIL_FLIT, 16'h0013);
        exp_pkt++;
        total++;
        if ({o_pkt_done, o_pkt_err, o_busy} !== 3'b100) begin
            bad++;
            $display("FAIL good_done: got done/err/busy=%b want 100", {o_pkt_done, o_pkt_err, o_busy});
        end
        total++;
        if (o_pkt_count !== 16'(exp_pkt) || o_last_addr !== 16'h0010 || o_checksum !== 16'h0000) begin
            bad++;
            $display("FAIL good_stats: got cnt=%h addr=%h csum=%h want %h 0010 0000",
                     o_pkt_count, o_last_addr, o_checksum, 16'(exp_pkt));
        end
        tick();
        total++;
        if (o_pkt_done !== 1'b0) begin
            bad++;
            $display("FAIL good_done_pulse: got %b want 0", o_pkt_done);
        end
        $display("good: cnt=%h addr=%h csum=%h", o_pkt_count, o_last_addr, o_checksum);
    endtask

    task automatic test_early_tail();
        request();
        drive(HEAD_FLIT, 16'h0020);
        drive(BODY_FLIT, 16'h0021);
        drive(TAIL_FLIT, 16'h0022);
        exp_err++;
        total++;
        if ({o_pkt_err, o_pkt_done, o_err_code} !== 4'b1001 || o_err_count !== 8'(exp_err)) begin
            bad++;
            $display("FAIL early_tail: got err=%b done=%b code=%0d errcnt=%h want 1 0 1 %h",
                     o_pkt_err, o_pkt_done, o_err_code, o_err_count, 8'(exp_err));
        end
        total++;
        if (o_pkt_count !== 16'(exp_pkt) || o_last_addr !== 16'h0010 || o_checksum !== 16'h0000) begin
            bad++;
            $display("FAIL early_tail_keep: got cnt=%h addr=%h csum=%h want %h 0010 0000",
                     o_pkt_count, o_last_addr, o_checksum, 16'(exp_pkt));
        end
        tick();
        total++;
        if (o_pkt_err !== 1'b0 || o_err_code !== 2'd1) begin
            bad++;
            $display("FAIL early_tail_hold: got err=%b code=%0d want 0 1", o_pkt_err, o_err_code);
        end
        $display("early tail: code=%0d errcnt=%h", o_err_code, o_err_count);
    endtask

    task automatic test_timeout();
        request();
        drive(HEAD_FLIT, 16'h0030);
        repeat (7) tick();
        total++;
        if ({o_pkt_err, o_busy} !== 2'b01) begin
            bad++;
            $display("FAIL timeout_7_idle: got err/busy=%b want 01", {o_pkt_err, o_busy});
        end
        drive(BODY_FLIT, 16'h0031);
        repeat (7) tick();
        total++;
        if ({o_pkt_err, o_busy} !== 2'b01) begin
            bad++;
            $display("FAIL timeout_reset_run: got err/busy=%b want 01", {o_pkt_err, o_busy});
        end
        tick();
        exp_err++;
        total++;
        if ({o_pkt_err, o_busy, o_err_code} !== 4'b1010 || o_err_count !== 8'(exp_err)) begin
            bad++;
            $display("FAIL timeout_8_idle: got err=%b busy=%b code=%0d errcnt=%h want 1 0 2 %h",
                     o_pkt_err, o_busy, o_err_code, o_err_count, 8'(exp_err));
        end
        request();
        repeat (7) tick();
        total++;
        if ({o_pkt_err, o_busy} !== 2'b01) begin
            bad++;
            $display("FAIL timeout_head_7: got err/busy=%b want 01", {o_pkt_err, o_busy});
        end
        tick();
        exp_err++;
        total++;
        if ({o_pkt_err, o_busy, o_err_code} !== 4'b1010) begin
            bad++;
            $display("FAIL timeout_head_8: got err=%b busy=%b code=%0d want 1 0 2",
                     o_pkt_err, o_busy, o_err_code);
        end
        $display("timeout: code=%0d errcnt=%h", o_err_code, o_err_count);
    endtask

    task automatic test_seq();
        request();
        drive(HEAD_FLIT, 16'h0010);
        drive(BODY_FLIT, 16'h0012);
`ifdef PACKET_SINK_SEQ_CHECK_EN
        exp_err++;
        total++;
        if ({o_pkt_err, o_err_code} !== 3'b111 || o_err_count !== 8'(exp_err)) begin
            bad++;
            $display("FAIL seq_err: got err=%b code=%0d errcnt=%h want 1 3 %h",
                     o_pkt_err, o_err_code, o_err_count, 8'(exp_err));
        end
`else
        total++;
        if (o_pkt_err !== 1'b0) begin
            bad++;
            $display("FAIL seq_nocheck_err: got %b want 0", o_pkt_err);
        end
        drive(BODY_FLIT, 16'h0013);
        drive(TAIL_FLIT, 16'h0014);
        exp_pkt++;
        total++;
        if (o_pkt_done !== 1'b1 || o_err_code !== 2'd0 || o_pkt_count !== 16'(exp_pkt) ||
            o_checksum !== 16'h0005) begin
            bad++;
            $display("FAIL seq_nocheck_done: got done=%b code=%0d cnt=%h csum=%h want 1 0 %h 0005",
                     o_pkt_done, o_err_code, o_pkt_count, o_checksum, 16'(exp_pkt));
        end
`endif
        $display("sequence: code=%0d done=%b", o_err_code, o_pkt_done);
    endtask

    task automatic test_framing();
        request();
        drive(BODY_FLIT, 16'h0060);
        exp_err++;
        total++;
        if ({o_pkt_err, o_err_code} !== 3'b101 || o_err_count !== 8'(exp_err)) begin
            bad++;
            $display("FAIL frame_body_first: got err=%b code=%0d errcnt=%h want 1 1 %h",
                     o_pkt_err, o_err_code, o_err_count, 8'(exp_err));
        end
        request();
        drive(HEAD_FLIT, 16'h0070);
        drive(BODY_FLIT, 16'h0071);
        drive(BODY_FLIT, 16'h0072);
        total++;
        if (o_pkt_err !== 1'b0) begin
            bad++;
            $display("FAIL frame_full_early: got %b want 0", o_pkt_err);
        end
        drive(BODY_FLIT, 16'h007F);
        exp_err++;
        total++;
        if ({o_pkt_err, o_err_code} !== 3'b101) begin
            bad++;
            $display("FAIL frame_extra_body: got err=%b code=%0d want 1 1", o_pkt_err, o_err_code);
        end
        request();
        drive(HEAD_FLIT, 16'h0080);
        drive(NONE_FLIT, 16'h0081);
        exp_err++;
        total++;
        if ({o_pkt_err, o_err_code} !== 3'b101) begin
            bad++;
            $display("FAIL frame_none: got err=%b code=%0d want 1 1", o_pkt_err, o_err_code);
        end
        request();
        drive(HEAD_FLIT, 16'h0090);
        drive(HEAD_FLIT, 16'h0091);
        exp_err++;
        total++;
        if ({o_pkt_err, o_err_code} !== 3'b101 || o_err_count !== 8'(exp_err) ||
            o_pkt_count !== 16'(exp_pkt)) begin
            bad++;
            $display("FAIL frame_head_in_body: got err=%b code=%0d errcnt=%h cnt=%h want 1 1 %h %h",
                     o_pkt_err, o_err_code, o_err_count, o_pkt_count, 8'(exp_err), 16'(exp_pkt));
        end
        $display("framing: errcnt=%h", o_err_count);
    endtask

    task automatic test_rereq();
        i_req = 1'b1;
        tick();
        tick();
        total++;
        if ({o_grant, o_busy} !== 2'b01) begin
            bad++;
            $display("FAIL rereq_busy_ignore: got grant/busy=%b want 01", {o_grant, o_busy});
        end
        drive(HEAD_FLIT, 16'h00A0);
        i_flit_valid = 1'b1;
        i_flit = mk(HEAD_FLIT, 16'h00FF, 1'b0);
        tick();
        i_flit_valid = 1'b0;
        total++;
        if ({o_pkt_err, o_busy, o_grant} !== 3'b010) begin
            bad++;
            $display("FAIL rereq_unqualified: got err/busy/grant=%b want 010", {o_pkt_err, o_busy, o_grant});
        end
        drive(BODY_FLIT, 16'h00A1);
        drive(BODY_FLIT, 16'h00A2);
        drive(TAIL_FLIT, 16'h00A3);
        exp_pkt++;
        total++;
        if ({o_pkt_done, o_busy, o_grant} !== 3'b100 || o_last_addr !== 16'h00A0 ||
            o_checksum !== 16'h0000) begin
            bad++;
            $display("FAIL rereq_done: got done/busy/grant=%b addr=%h csum=%h want 100 00a0 0000",
                     {o_pkt_done, o_busy, o_grant}, o_last_addr, o_checksum);
        end
        tick();
        total++;
        if (o_grant !== 1'b1) begin
            bad++;
            $display("FAIL rereq_regrant: got %b want 1", o_grant);
        end
        i_req = 1'b0;
        tick();
        drive(BODY_FLIT, 16'h0000);
        exp_err++;
        $display("rereq: regranted, cnt=%h", o_pkt_count);
    endtask

    task automatic test_reset_mid();
        request();
        drive(HEAD_FLIT, 16'h0040);
        drive(BODY_FLIT, 16'h0041);
        reset_n = 1'b0;
        tick();
        total++;
        if ({o_busy, o_grant, o_pkt_done, o_pkt_err, o_err_code, o_pkt_count, o_err_count,
             o_last_addr, o_checksum} !== 72'h0) begin
            bad++;
            $display("FAIL reset_mid_outputs: got busy=%b cnt=%h err=%h addr=%h csum=%h want all 0",
                     o_busy, o_pkt_count, o_err_count, o_last_addr, o_checksum);
        end
        reset_n = 1'b1;
        exp_pkt = 0;
        exp_err = 0;
        request();
        drive(HEAD_FLIT, 16'h0050);
        drive(BODY_FLIT, 16'h0051);
        drive(BODY_FLIT, 16'h0052);
        drive(TAIL_FLIT, 16'h0053);
        exp_pkt++;
        total++;
        if (o_pkt_done !== 1'b1 || o_pkt_count !== 16'h0001 || o_last_addr !== 16'h0050 ||
            o_checksum !== 16'h0000) begin
            bad++;
            $display("FAIL reset_mid_recover: got done=%b cnt=%h addr=%h csum=%h want 1 0001 0050 0000",
                     o_pkt_done, o_pkt_count, o_last_addr, o_checksum);
        end
        $display("reset mid-packet: cnt=%h addr=%h", o_pkt_count, o_last_addr);
    endtask

    task automatic test_err_sat();
        for (int i = 0; i < 260; i++) begin
            request();
            drive(BODY_FLIT, 16'h0000);
            if (exp_err < 255) exp_err++;
        end
        total++;
        if (o_err_count !== 8'hFF || o_err_count !== 8'(exp_err)) begin
            bad++;
            $display("FAIL err_sat: got %h want ff", o_err_count);
        end
        total++;
        if (o_pkt_count !== 16'(exp_pkt)) begin
            bad++;
            $display("FAIL err_sat_pkt: got %h want %h", o_pkt_count, 16'(exp_pkt));
        end
        $display("error saturation: errcnt=%h", o_err_count);
    endtask

    task automatic test_pkt_sat();
        force dut.pkt_count_q = 16'hFFFE;
        tick();
        release dut.pkt_count_q;
        tick();
        total++;
        if (o_pkt_count !== 16'hFFFE) begin
            bad++;
            $display("FAIL pkt_sat_preload: got %h want fffe", o_pkt_count);
        end
        for (int n = 0; n < 2; n++) begin
            request();
            drive(HEAD_FLIT, 16'h1000);
            drive(BODY_FLIT, 16'h1001);
            drive(BODY_FLIT, 16'h1002);
            drive(TAIL_FLIT, 16'h1003);
            total++;
            if (o_pkt_done !== 1'b1 || o_pkt_count !== 16'hFFFF) begin
                bad++;
                $display("FAIL pkt_sat_%0d: got done=%b cnt=%h want 1 ffff", n, o_pkt_done, o_pkt_count);
            end
            $display("packet saturation step %0d: cnt=%h", n, o_pkt_count);
        end
    endtask

    initial begin
        test_reset();
        test_idle_ignore();
        test_good();
        test_early_tail();
        test_timeout();
        test_seq();
        test_framing();
        test_rereq();
        test_reset_mid();
        test_err_sat();
        test_pkt_sat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
